// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the VGA timing generator. The default timing is
// 1024x768@60 Hz with a 65 MHz pixel clock. The top level uses these
// values as its parameter defaults.
// It also provides a small helper function for inclusive window checks,
// which the sync outputs use.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Counter widths: 11 bits covers every count up to 2047.
  localparam int unsigned CNT_W       = 11;
  localparam int unsigned FRAME_CNT_W = 16;

  // 1024x768@60 horizontal timing, in pixel clocks.
  localparam int unsigned VGA_H_ACTIVE     = 1024;
  localparam int unsigned VGA_H_SYNC_START = 1048;
  localparam int unsigned VGA_H_SYNC_END   = 1183;
  localparam int unsigned VGA_H_TOTAL      = 1344;

  // 1024x768@60 vertical timing, in lines.
  localparam int unsigned VGA_V_ACTIVE     = 768;
  localparam int unsigned VGA_V_SYNC_START = 771;
  localparam int unsigned VGA_V_SYNC_END   = 776;
  localparam int unsigned VGA_V_TOTAL      = 806;

  // Returns true when lo <= c <= hi, using unsigned 11-bit arithmetic.
  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/timing_counter.sv
// ---------------------------------------------------------------------------
// timing_counter
// Modulo-TOTAL up-counter with an enable input. The counter exposes its
// registered value and also its next value. The parent can use the next
// value to register derived flags in the same cycle as the count.
//
// Ports
//   clk_i    clock; the count updates on the rising edge
//   rst_i    asynchronous active-high reset; clears the count to 0
//   en_i     count enable
//   count_o  current registered count
//   next_o   value the count takes on the next rising edge
//   wrap_o   high when the next edge takes the count from TOTAL-1 to 0
// ---------------------------------------------------------------------------
module timing_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W,
  parameter int unsigned TOTAL = VGA_H_TOTAL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap;

  // wrap is combinational so that a dependent counter can use it as its
  // enable and advance on the same edge.
  always_comb begin
    wrap    = en_i && (count_q == LAST);
    count_d = count_q;
    if (en_i) begin
      count_d = wrap ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;
  assign wrap_o  = wrap;

endmodule

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Generates raster timing for a VGA display: pixel and line counters,
// sync pulses, blanking flags, a frame-start pulse, and a frame counter.
// Every output comes directly from a flop.
//
// Ports
//   pclk             pixel clock; all state updates on the rising edge
//   rst              asynchronous active-high reset
//   hcount_out       current pixel column, 0..H_TOTAL-1
//   vcount_out       current line, 0..V_TOTAL-1
//   hsync_out        high while H_SYNC_START <= hcount <= H_SYNC_END
//   hblnk_out        high while hcount >= H_ACTIVE
//   vsync_out        high while V_SYNC_START <= vcount <= V_SYNC_END
//   vblnk_out        high while vcount >= V_ACTIVE
//   frame_start_out  one-cycle pulse when the counters wrap into (0,0)
//   frame_cnt_out    frames completed since reset (wraps at 16 bits)
// ---------------------------------------------------------------------------
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
  parameter int unsigned H_SYNC_START = VGA_H_SYNC_START,
  parameter int unsigned H_SYNC_END   = VGA_H_SYNC_END,
  parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
  parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
  parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
  parameter int unsigned V_SYNC_END   = VGA_V_SYNC_END,
  parameter int unsigned V_TOTAL      = VGA_V_TOTAL
) (
  input  logic                   pclk,
  input  logic                   rst,
  output logic [CNT_W-1:0]       hcount_out,
  output logic [CNT_W-1:0]       vcount_out,
  output logic                   hsync_out,
  output logic                   hblnk_out,
  output logic                   vsync_out,
  output logic                   vblnk_out,
  output logic                   frame_start_out,
  output logic [FRAME_CNT_W-1:0] frame_cnt_out
);

  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS  = CNT_W'(H_SYNC_START);
  localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_SYNC_END);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS  = CNT_W'(V_SYNC_START);
  localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_SYNC_END);

  logic [CNT_W-1:0]       h_next;
  logic [CNT_W-1:0]       v_next;
  logic                   h_wrap;
  logic                   v_wrap;
  logic                   frame_start_d;
  logic                   hsync_q;
  logic                   hblnk_q;
  logic                   vsync_q;
  logic                   vblnk_q;
  logic                   frame_start_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;

  timing_counter #(
    .WIDTH (CNT_W),
    .TOTAL (H_TOTAL)
  ) u_hcounter (
    .clk_i   (pclk),
    .rst_i   (rst),
    .en_i    (1'b1),
    .count_o (hcount_out),
    .next_o  (h_next),
    .wrap_o  (h_wrap)
  );

  // The line counter advances only on the cycle the pixel counter wraps.
  timing_counter #(
    .WIDTH (CNT_W),
    .TOTAL (V_TOTAL)
  ) u_vcounter (
    .clk_i   (pclk),
    .rst_i   (rst),
    .en_i    (h_wrap),
    .count_o (vcount_out),
    .next_o  (v_next),
    .wrap_o  (v_wrap)
  );

  // The vertical wrap already requires the horizontal wrap, so this flag
  // marks only the step from (H_TOTAL-1, V_TOTAL-1) to (0,0). Entering
  // (0,0) through reset does not produce a pulse.
  assign frame_start_d = v_wrap;
  assign frame_cnt_d   = frame_cnt_q + FRAME_CNT_W'(1);

  // The flags are decoded from the counters' next values. They then
  // register on the same edge as the counts and stay aligned with them.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hsync_q       <= in_window(h_next, H_SS, H_SE);
      hblnk_q       <= (h_next >= H_ACT);
      vsync_q       <= in_window(v_next, V_SS, V_SE);
      vblnk_q       <= (v_next >= V_ACT);
      frame_start_q <= frame_start_d;
      if (frame_start_d) begin
        frame_cnt_q <= frame_cnt_d;
      end
    end
  end

  assign hsync_out       = hsync_q;
  assign hblnk_out       = hblnk_q;
  assign vsync_out       = vsync_q;
  assign vblnk_out       = vblnk_q;
  assign frame_start_out = frame_start_q;
  assign frame_cnt_out   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
// Directed testbench for vga_timing. It uses two instances:
//   dutDef   - default 1024x768 timing, used for the horizontal boundaries
//   dutSmall - a tiny raster (24x14) so whole frames are short
//              H: active 16, sync 18..21, total 24
//              V: active 10, sync 11..12, total 14  -> 336 cycles per frame
// ---------------------------------------------------------------------------
module tb_vga_timing;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [10:0] dHcount, dVcount;
  logic        dHsync, dHblnk, dVsync, dVblnk, dFrameStart;
  logic [15:0] dFrameCnt;

  logic [10:0] sHcount, sVcount;
  logic        sHsync, sHblnk, sVsync, sVblnk, sFrameStart;
  logic [15:0] sFrameCnt;

  int errors = 0;
  int checks = 0;
  int n      = 0;

  always #5 clock = ~clock;

  vga_timing dutDef (
    .pclk            (clock),
    .rst             (reset),
    .hcount_out      (dHcount),
    .vcount_out      (dVcount),
    .hsync_out       (dHsync),
    .hblnk_out       (dHblnk),
    .vsync_out       (dVsync),
    .vblnk_out       (dVblnk),
    .frame_start_out (dFrameStart),
    .frame_cnt_out   (dFrameCnt)
  );

  vga_timing #(
    .H_ACTIVE     (16),
    .H_SYNC_START (18),
    .H_SYNC_END   (21),
    .H_TOTAL      (24),
    .V_ACTIVE     (10),
    .V_SYNC_START (11),
    .V_SYNC_END   (12),
    .V_TOTAL      (14)
  ) dutSmall (
    .pclk            (clock),
    .rst             (reset),
    .hcount_out      (sHcount),
    .vcount_out      (sVcount),
    .hsync_out       (sHsync),
    .hblnk_out       (sHblnk),
    .vsync_out       (sVsync),
    .vblnk_out       (sVblnk),
    .frame_start_out (sFrameStart),
    .frame_cnt_out   (sFrameCnt)
  );

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advances to the falling edge that follows the given number of rising edges.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  // Advances to the point where 'target' rising edges have passed since reset was released.
  task automatic stepTo(input int target);
    applyStimulus(target - n);
    n = target;
  endtask

  task automatic checkDefZero(input string tag);
    checkOutput({tag, " def hcount"}, 32'(dHcount), 0);
    checkOutput({tag, " def vcount"}, 32'(dVcount), 0);
    checkOutput({tag, " def syncblank"}, 32'({dHsync, dHblnk, dVsync, dVblnk}), 0);
    checkOutput({tag, " def fstart"}, 32'(dFrameStart), 0);
    checkOutput({tag, " def fcnt"}, 32'(dFrameCnt), 0);
  endtask

  task automatic checkSmallZero(input string tag);
    checkOutput({tag, " small hcount"}, 32'(sHcount), 0);
    checkOutput({tag, " small vcount"}, 32'(sVcount), 0);
    checkOutput({tag, " small syncblank"}, 32'({sHsync, sHblnk, sVsync, sVblnk}), 0);
    checkOutput({tag, " small fstart"}, 32'(sFrameStart), 0);
    checkOutput({tag, " small fcnt"}, 32'(sFrameCnt), 0);
  endtask

  // Checks the default-timing instance's horizontal outputs at cycle 'at'.
  task automatic checkDef(input int at, input int h, input int v,
                          input bit hs, input bit hb);
    stepTo(at);
    checkOutput($sformatf("def hcount@%0d", at), 32'(dHcount), h);
    checkOutput($sformatf("def vcount@%0d", at), 32'(dVcount), v);
    checkOutput($sformatf("def hsync@%0d", at), 32'(dHsync), 32'(hs));
    checkOutput($sformatf("def hblnk@%0d", at), 32'(dHblnk), 32'(hb));
  endtask

  // Checks the small instance's frame pulse and frame count at cycle 'at'.
  task automatic checkFrame(input int at, input bit fs, input int cnt);
    stepTo(at);
    checkOutput($sformatf("small fstart@%0d", at), 32'(sFrameStart), 32'(fs));
    checkOutput($sformatf("small fcnt@%0d", at), 32'(sFrameCnt), cnt);
  endtask

  initial begin
    int eh, ev;

    // Reset held: everything must be zero.
    applyStimulus(3);
    checkDefZero("reset");
    checkSmallZero("reset");

    // Release reset, then run the first line of the default raster.
    reset = 1'b0;
    n = 0;
    checkDef(1, 1, 0, 1'b0, 1'b0);
    checkDef(1023, 1023, 0, 1'b0, 1'b0);
    checkDef(1024, 1024, 0, 1'b0, 1'b1);
    checkDef(1047, 1047, 0, 1'b0, 1'b1);
    checkDef(1048, 1048, 0, 1'b1, 1'b1);
    checkDef(1183, 1183, 0, 1'b1, 1'b1);
    checkDef(1184, 1184, 0, 1'b0, 1'b1);
    checkDef(1343, 1343, 0, 1'b0, 1'b1);
    checkDef(1344, 0, 1, 1'b0, 1'b0);
    checkOutput("def vsync line1", 32'(dVsync), 0);
    checkOutput("def vblnk line1", 32'(dVblnk), 0);
    checkOutput("def fstart line1", 32'(dFrameStart), 0);

    // Fresh reset, then check one full small frame cycle by cycle.
    reset = 1'b1;
    applyStimulus(2);
    reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 336; i++) begin
      stepTo(i);
      eh = i % 24;
      ev = (i / 24) % 14;
      checkOutput($sformatf("small hcount@%0d", i), 32'(sHcount), eh);
      checkOutput($sformatf("small vcount@%0d", i), 32'(sVcount), ev);
      checkOutput($sformatf("small hsync@%0d", i), 32'(sHsync), 32'(eh >= 18 && eh <= 21));
      checkOutput($sformatf("small hblnk@%0d", i), 32'(sHblnk), 32'(eh >= 16));
      checkOutput($sformatf("small vsync@%0d", i), 32'(sVsync), 32'(ev >= 11 && ev <= 12));
      checkOutput($sformatf("small vblnk@%0d", i), 32'(sVblnk), 32'(ev >= 10));
      checkOutput($sformatf("small fstart@%0d", i), 32'(sFrameStart), 32'(i == 336));
      checkOutput($sformatf("small fcnt@%0d", i), 32'(sFrameCnt), 32'(i / 336));
    end
    checkFrame(337, 1'b0, 1);
    checkFrame(671, 1'b0, 1);
    checkFrame(672, 1'b1, 2);
    checkFrame(673, 1'b0, 2);
    checkFrame(1007, 1'b0, 2);
    checkFrame(1008, 1'b1, 3);

    // Mid-frame asynchronous reset at (10,5) of the small raster.
    stepTo(1008 + 130);
    checkOutput("pre-rst small hcount", 32'(sHcount), 10);
    checkOutput("pre-rst small vcount", 32'(sVcount), 5);
    checkOutput("pre-rst small fcnt", 32'(sFrameCnt), 3);
    #2;
    reset = 1'b1;
    #1;
    checkDefZero("async");
    checkSmallZero("async");
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    stepTo(1);
    checkOutput("restart def hcount", 32'(dHcount), 1);
    checkOutput("restart def vcount", 32'(dVcount), 0);
    checkOutput("restart small hcount", 32'(sHcount), 1);
    checkOutput("restart small vcount", 32'(sVcount), 0);
    checkOutput("restart small fcnt", 32'(sFrameCnt), 0);

    // Force the frame counter to 65535 near the end of the first frame.
    stepTo(330);
    force dutSmall.frame_cnt_q = 16'hFFFF;
    stepTo(335);
    release dutSmall.frame_cnt_q;
    #1;
    checkOutput("preload fcnt", 32'(sFrameCnt), 65535);
    checkOutput("preload fstart", 32'(sFrameStart), 0);
    checkFrame(336, 1'b1, 0);
    checkFrame(337, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop so that the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
